// File: rtl/lsu_seq.sv
// Load/store sequencer: one request at a time, splits misaligned half/word accesses into
// byte beats, reassembles and extends load data, and returns a single-cycle response.
module lsu_seq #(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_data_i,
  input  logic [2:0]        req_funct3_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d, last_q;
  logic              we_q, split_q, err_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q, asm_q, rdata_q;
  logic [2:0]        funct3_q;

  logic       req_legal, req_misal, req_err, req_split;
  logic [1:0] req_last;

  always_comb begin
    unique case (req_funct3_i)
      3'd0, 3'd1, 3'd2: req_legal = 1'b1;
      3'd4, 3'd5:       req_legal = !req_we_i;
      default:          req_legal = 1'b0;
    endcase
    req_misal = (req_funct3_i[1:0] == 2'd1 && req_addr_i[0]) ||
                (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0);
    req_err   = !req_legal || (req_misal && !MISALIGN_EN);
    req_split = req_misal && MISALIGN_EN;
    req_last  = !req_split ? 2'd0 : (req_funct3_i[1:0] == 2'd1) ? 2'd1 : 2'd3;
  end

  // Raw load word: either the memory word, or the assembly register with the current byte merged.
  logic [DWIDTH-1:0] raw, ext;
  always_comb begin
    raw = mem_data_i;
    if (split_q) begin
      raw = asm_q;
      raw[{beat_q, 3'b000} +: 8] = mem_data_i[7:0];
    end
    case (funct3_q)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ext = {24'h0, raw[7:0]};
      3'd5:    ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        beat_d = 2'd0;
        if (req_valid_i) state_d = req_err ? StResp : StAccess;
      end
      StAccess: begin
        if (beat_q == last_q) begin
          state_d = StResp;
          beat_d  = 2'd0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 2'd0;
      addr_q   <= '0;
      data_q   <= '0;
      funct3_q <= 3'd0;
      asm_q    <= '0;
      rdata_q  <= '0;
    end else if (state_q == StIdle && req_valid_i) begin
      we_q     <= req_we_i;
      split_q  <= req_split;
      err_q    <= req_err;
      last_q   <= req_last;
      addr_q   <= req_addr_i;
      data_q   <= req_data_i;
      funct3_q <= req_funct3_i;
      asm_q    <= '0;
      rdata_q  <= '0;
    end else if (state_q == StAccess) begin
      if (split_q) asm_q <= raw;
      if (beat_q == last_q) rdata_q <= we_q ? '0 : ext;
    end
  end

  // Every output is forced low while reset is asserted, even before the reset edge lands.
  always_comb begin
    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_rdata_o   = '0;
    resp_err_o     = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = 3'd0;
    if (rst) begin
      unique case (state_q)
        StIdle: req_ready_o = 1'b1;
        StAccess: begin
          mem_addr_o     = addr_q + AWIDTH'(beat_q);
          mem_read_en_o  = !we_q;
          mem_write_en_o = we_q;
          if (split_q) begin
            mem_funct3_o = we_q ? 3'd0 : 3'd4;
            mem_data_o   = DWIDTH'(data_q[{beat_q, 3'b000} +: 8]);
          end else begin
            mem_funct3_o = funct3_q;
            mem_data_o   = data_q;
          end
        end
        StResp: begin
          resp_valid_o = 1'b1;
          resp_rdata_o = rdata_q;
          resp_err_o   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Load/store sequencer between the execute stage and the byte-addressable data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, data, read/write enables and funct3.
- Splits misaligned halfword and word accesses into per-byte memory accesses, reassembles and sign-extends load data, and returns a single-cycle response.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; only 32 is supported.
- MISALIGN_EN, 1, 1: misaligned accesses are split into byte beats; 0: misaligned accesses return an error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (0 = reset).
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  AWIDTH  byte address.
- req_data_i  in  DWIDTH  store data, right-aligned.
- req_funct3_i  in  3  RV32I load/store funct3.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  DWIDTH  load result, sign/zero-extended; 0 for stores and errors.
- resp_err_o  out  1  illegal funct3, or misaligned with MISALIGN_EN=0.
- mem_addr_o  out  AWIDTH  memory address.
- mem_data_o  out  DWIDTH  memory write data.
- mem_read_en_o  out  1  memory read enable.
- mem_write_en_o  out  1  memory write enable.
- mem_funct3_o  out  3  memory access size.
- mem_data_i  in  DWIDTH  memory combinational read data.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; beat counter=0; assembly register=0.
  - All outputs 0 except req_ready_o=1 once in IDLE.
  - Applies mid-operation: remaining beats are abandoned, and bytes already written stay written (partial store permitted).
- States: IDLE, ACCESS, RESP.
  - IDLE: req_ready_o=1. On req_valid_i, latch we/addr/data/funct3, classify, then go to ACCESS, or to RESP with err=1.
  - ACCESS: req_ready_o=0. Run beat k (k=0..N-1). After the last beat, go to RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0.
- Legal funct3:
  - Loads: 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU).
  - Stores: 0 (SB), 1 (SH), 2 (SW).
  - Any other value is an error: no memory enable asserted, latency 1 (resp one cycle after acceptance).
- Alignment:
  - Byte accesses are always aligned.
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
- Aligned access: N=1.
  - mem_addr_o=addr, mem_funct3_o=latched funct3, mem_data_o=latched data.
  - Load data is taken from mem_data_i in that ACCESS cycle.
- Misaligned access (MISALIGN_EN=1): N=2 (halfword) or 4 (word).
  - Beat k: mem_addr_o=addr+k, modulo 2^AWIDTH (wrap-around permitted).
  - Store beat: mem_funct3_o=0 (SB), mem_data_o[7:0]=data byte k, upper bits 0.
  - Load beat: mem_funct3_o=4 (LBU); mem_data_i[7:0] is captured into assembly byte k.
  - Final result is extended per the original funct3 (LH sign-extends bit 15, LHU zero-extends).
- Enables during ACCESS:
  - mem_read_en_o=!we and mem_write_en_o=we, every beat.
  - Both enables are 0 in IDLE and RESP; mem_addr_o, mem_data_o and mem_funct3_o are 0 outside ACCESS.
- Latency: acceptance at edge T; beats in cycles T+1..T+N; resp_valid_o in cycle T+N+1.
- Results are registered. resp_rdata_o and resp_err_o hold their value only during resp_valid_o and are 0 otherwise.
- No response backpressure: the consumer must take the response in the pulse cycle.
- req_valid_i asserted while busy is ignored until IDLE; the requester must hold its request stable.
- Back-to-back: minimum request spacing is N+2 cycles.

Test Plan:
- Aligned SW 0xDEADBEEF at 0x01000100, then LW 0x01000100:
  - Each request gives one ACCESS beat with funct3=2.
  - resp at T+2; LW rdata=0xDEADBEEF, err=0.
- Misaligned LH at 0x01000101 with bytes [0x101]=0x80, [0x102]=0xFF:
  - Two LBU beats, at addresses 0x01000101 then 0x01000102.
  - resp at T+3, rdata=0xFFFFFF80; the same access as LHU gives 0x0000FF80.
- Misaligned SW 0x11223344 at 0x01000103:
  - Four SB beats writing 0x44, 0x33, 0x22, 0x11 to 0x103..0x106.
  - resp at T+5; a following aligned LW 0x01000104 returns 0x00112233 when byte 0x107 is 0x00.
- Load with funct3=3:
  - resp_err_o=1 and rdata=0 at T+1.
  - mem_read_en_o and mem_write_en_o never asserted.
  - MISALIGN_EN=0 with LW at 0x01000102 also gives err=1 and no memory access.
- Reset mid-operation: rst=0 after beat 1 of a misaligned SW 0xAABBCCDD at 0x01000101.
  - Only bytes 0x101=0xDD and 0x102=0xCC are written; no response is issued.
  - All outputs are 0 during reset; req_ready_o=1 in the first cycle after rst returns to 1.
- Request held asserted during a 4-beat access:
  - req_ready_o=0 until IDLE.
  - The second request is accepted exactly one cycle after the first response pulse.
